spi_master_mc: RTL

Parametrised multi-chip-select SPI master. Successor to the single-mode master.
- Adds runtime SPI mode (CPOL/CPHA), a runtime clock divider, per-transfer bit count and bit order, and one-hot active-low chip selects with lead, trail and inter-transfer gap timing.
- Sits between a register/bus front-end and the SPI pads.
- Performs one full-duplex transfer per accepted request.

---
 rtl/spi_master_mc_pkg.sv | 22 ++
 rtl/spi_master_mc_clk_div.sv | 47 ++++
 rtl/spi_master_mc.sv | 139 +++++++++++++
 3 files changed

// File: rtl/spi_master_mc_pkg.sv
// Shared constants for the multi-chip-select SPI master: FSM encoding,
// SPI mode encodings ({CPOL, CPHA}) and default widths.
package spi_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CNT_W  = 7;
  localparam int DEF_NUM_CS = 4;
  localparam int DEF_CS_W   = 2;
  localparam int DEF_DIV_W  = 8;

endpackage

// File: rtl/spi_master_mc_clk_div.sv
// Loadable SCK half-period counter: one-cycle tick every D clk cycles while
// running, plus a leading/trailing edge parity flag for the SHIFT phase.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int P_DIV_W = DEF_DIV_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [P_DIV_W-1:0] div,
  input  logic               par_en,
  output logic               tick,
  output logic               lead
);

  logic [P_DIV_W-1:0] d_q;
  logic [P_DIV_W-1:0] cnt_q;
  logic               run_q;
  logic               par_q;

  assign tick = run_q && (cnt_q == d_q - P_DIV_W'(1));
  // Parity only advances on SHIFT edges, so it restarts at "leading" each transfer.
  assign lead = ~par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= P_DIV_W'(1);
      cnt_q <= '0;
      run_q <= 1'b0;
      par_q <= 1'b0;
    end else if (start) begin
      d_q   <= (div == '0) ? P_DIV_W'(1) : div;
      cnt_q <= '0;
      run_q <= 1'b1;
      par_q <= 1'b0;
    end else if (stop) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (run_q) begin
      cnt_q <= tick ? '0 : cnt_q + P_DIV_W'(1);
      if (tick && par_en) par_q <= ~par_q;
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-CS SPI master: runtime mode/divider/bit count/bit order, one full-duplex
// transfer per request. Optional SPI_MASTER_MC_LOOPBACK_EN adds i_loopback.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int P_DATA_W = DEF_DATA_W,
  parameter int P_CNT_W  = DEF_CNT_W,
  parameter int P_NUM_CS = DEF_NUM_CS,
  parameter int P_CS_W   = DEF_CS_W,
  parameter int P_DIV_W  = DEF_DIV_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [P_DATA_W-1:0] ip_data,
  input  logic [P_CNT_W-1:0]  ip_bit_count,
  input  logic [P_CS_W-1:0]   ip_cs_sel,
  input  logic                i_cpol,
  input  logic                i_cpha,
  input  logic                i_lsb_first,
  input  logic [P_DIV_W-1:0]  ip_div,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [P_DATA_W-1:0] orp_data,
  output logic                o_rdata_valid,
  output logic                o_busy,
  output logic                o_sck,
  output logic                or_mosi,
  input  logic                i_miso,
`ifdef SPI_MASTER_MC_LOOPBACK_EN
  input  logic                i_loopback,
`endif
  output logic [P_NUM_CS-1:0] o_cs_n
);

  logic [2:0]          state;
  logic [P_DATA_W-1:0] tx_q, rx_q;
  logic [P_CNT_W-1:0]  n_q, k_q, n_in;
  logic                cpha_q, lsb_q, lb_q, lb_in;
  logic [P_NUM_CS-1:0] cs_dec;
  logic                tick, lead, accept, last, rx_in;

  // Stream bit k maps to buffer index k (LSB-first) or n-1-k (MSB-first).
  function automatic logic [P_CNT_W-2:0] bidx(input logic [P_CNT_W-1:0] k,
                                              input logic [P_CNT_W-1:0] n,
                                              input logic lsb);
    logic [P_CNT_W-1:0] t;
    t = lsb ? k : n - k - P_CNT_W'(1);
    return t[P_CNT_W-2:0];
  endfunction

`ifdef SPI_MASTER_MC_LOOPBACK_EN
  assign lb_in = i_loopback;
`else
  assign lb_in = 1'b0;
`endif

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign accept  = o_ready && i_valid;
  assign last    = (k_q == n_q - P_CNT_W'(1));
  assign rx_in   = lb_q ? or_mosi : i_miso;
  assign n_in    = (ip_bit_count == '0 || 32'(ip_bit_count) > P_DATA_W)
                   ? P_CNT_W'(P_DATA_W) : ip_bit_count;

  always_comb begin
    cs_dec = '1;
    if (!lb_in && (32'(ip_cs_sel) < P_NUM_CS)) cs_dec[ip_cs_sel] = 1'b0;
  end

  spi_clk_div #(.P_DIV_W(P_DIV_W)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .stop   ((state == GAP) && tick),
    .div    (ip_div),
    .par_en (state == SHIFT),
    .tick   (tick),
    .lead   (lead)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tx_q          <= '0;
      rx_q          <= '0;
      n_q           <= P_CNT_W'(1);
      k_q           <= '0;
      cpha_q        <= 1'b0;
      lsb_q         <= 1'b0;
      lb_q          <= 1'b0;
      o_cs_n        <= '1;
      o_sck         <= 1'b0;
      or_mosi       <= 1'b0;
      orp_data      <= '0;
      o_rdata_valid <= 1'b0;
    end else begin
      o_rdata_valid <= 1'b0;
      case (state)
        IDLE: if (i_valid) begin
          state   <= SETUP;
          tx_q    <= ip_data;
          rx_q    <= '0;
          n_q     <= n_in;
          k_q     <= '0;
          cpha_q  <= i_cpha;
          lsb_q   <= i_lsb_first;
          lb_q    <= lb_in;
          o_cs_n  <= cs_dec;
          o_sck   <= i_cpol;
          or_mosi <= i_cpha ? 1'b0 : ip_data[bidx('0, n_in, i_lsb_first)];
        end
        SETUP: if (tick) state <= SHIFT;
        SHIFT: if (tick) begin
          o_sck <= ~o_sck;
          if (lead) begin
            if (cpha_q) or_mosi <= tx_q[bidx(k_q, n_q, lsb_q)];
            else        rx_q[bidx(k_q, n_q, lsb_q)] <= rx_in;
          end else begin
            // Trailing edge closes bit k; CPHA=0 launches the next bit here.
            if (cpha_q)     rx_q[bidx(k_q, n_q, lsb_q)] <= rx_in;
            else if (!last) or_mosi <= tx_q[bidx(k_q + P_CNT_W'(1), n_q, lsb_q)];
            k_q <= k_q + P_CNT_W'(1);
            if (last) state <= HOLD;
          end
        end
        HOLD: if (tick) begin
          state         <= GAP;
          o_cs_n        <= '1;
          or_mosi       <= 1'b0;
          orp_data      <= rx_q;
          o_rdata_valid <= 1'b1;
        end
        GAP: if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
